// File: rtl/bus_initiator_pkg.sv
// rtl/bus_initiator_pkg.sv - shared opcodes, FSM states and helpers for bus_initiator
// Purpose: opcode encodings, controller state enumeration and a 16-bit
//          saturating increment shared by bus_initiator and poll_timer.
// Ports:   none (package).
package bus_initiator_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_POLL  = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        POLL_RD,
        POLL_WAIT,
        RESP
    } state_t;

    localparam int CNT_W = 16;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/poll_timer.sv
// rtl/poll_timer.sv - poll read counter and inter-read gap timer
// Purpose: counts poll reads (16-bit, saturating) and times the idle gap
//          between consecutive poll reads.
// Ports:   clk, rst     - clock, asynchronous active-high reset
//          load         - clear the read count and the gap timer (command accepted)
//          tick         - a poll read happens this cycle; bump count, start gap
//          expire       - current cycle is the last idle cycle of the gap
//          count        - number of poll reads done so far for this command
module poll_timer
    import bus_initiator_pkg::*;
#(
    parameter int GAP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             tick,
    output logic             expire,
    output logic [CNT_W-1:0] count
);

    localparam int GW = $clog2(GAP + 1);

    logic [GW-1:0] gap_cnt;

    // gap_cnt is loaded with GAP on a poll read and counts down once per
    // idle cycle, so it reads 1 in the GAP-th idle cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            gap_cnt <= '0;
        end else begin
            if (load) begin
                count   <= '0;
                gap_cnt <= '0;
            end else if (tick) begin
                count   <= sat_inc(count);
                gap_cnt <= GW'(GAP);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

    assign expire = (gap_cnt == GW'(1));

endmodule

// File: rtl/bus_initiator.sv
// rtl/bus_initiator.sv - command-driven simple bus initiator with write, read and poll
// Purpose: accepts write/read/poll commands, runs them on a single-cycle
//          bus and returns one response per command.
// Ports:   Clk, Rst                         - clock, asynchronous active-high reset
//          cmd_valid/ready/op/addr/data/mask - command handshake and fields
//          rsp_valid/ready/data/timeout/err  - response handshake and fields
//          addr_dm, wd_dm, we, rd_dm         - bus address, write data, write enable, read data
//          stat_wr, stat_rd, stat_to         - completion counters, present only
//                                              when BUS_INITIATOR_STATS_EN is defined
module bus_initiator
    import bus_initiator_pkg::*;
#(
    parameter int POLL_TIMEOUT = 1024,
    parameter int POLL_GAP     = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic [31:0] cmd_mask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_timeout,
    output logic        rsp_err,
    output logic [31:0] addr_dm,
    output logic [31:0] wd_dm,
    output logic        we,
`ifdef BUS_INITIATOR_STATS_EN
    output logic [15:0] stat_wr,
    output logic [15:0] stat_rd,
    output logic [15:0] stat_to,
`endif
    input  logic [31:0] rd_dm
);

    // The read that brings the count to POLL_TIMEOUT is the last one.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(POLL_TIMEOUT - 1);

    state_t           state;
    logic [31:0]      data_q;
    logic [31:0]      mask_q;
    logic             accept;
    logic             gap_expire;
    logic [CNT_W-1:0] poll_count;
    logic             poll_hit;
    logic             poll_last;

    assign accept    = (state == IDLE) && cmd_valid && cmd_ready;
    assign poll_hit  = ((rd_dm & mask_q) == (data_q & mask_q));
    assign poll_last = (poll_count == LAST_CNT);

    poll_timer #(
        .GAP (POLL_GAP)
    ) u_poll_timer (
        .clk    (Clk),
        .rst    (Rst),
        .load   (accept),
        .tick   (state == POLL_RD),
        .expire (gap_expire),
        .count  (poll_count)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= IDLE;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
            rsp_err     <= 1'b0;
            addr_dm     <= '0;
            wd_dm       <= '0;
            we          <= 1'b0;
            data_q      <= '0;
            mask_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cmd_ready   <= 1'b0;
                        data_q      <= cmd_data;
                        mask_q      <= cmd_mask;
                        rsp_data    <= '0;
                        rsp_timeout <= 1'b0;
                        rsp_err     <= 1'b0;
                        case (op_t'(cmd_op))
                            OP_WRITE: begin
                                state   <= WRITE;
                                we      <= 1'b1;
                                addr_dm <= cmd_addr;
                                wd_dm   <= cmd_data;
                            end
                            OP_READ: begin
                                state   <= READ;
                                addr_dm <= cmd_addr;
                            end
                            OP_POLL: begin
                                state   <= POLL_RD;
                                addr_dm <= cmd_addr;
                            end
                            default: begin
                                // Reserved opcode: answer at once, leave the bus untouched.
                                state     <= RESP;
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b1;
                            end
                        endcase
                    end else begin
                        // Also raises cmd_ready on the first edge after reset.
                        cmd_ready <= 1'b1;
                    end
                end
                WRITE: begin
                    we        <= 1'b0;
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                end
                READ: begin
                    rsp_data  <= rd_dm;
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                end
                POLL_RD: begin
                    rsp_data <= rd_dm;
                    if (poll_hit) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end else if (poll_last) begin
                        state       <= RESP;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end else begin
                        state <= POLL_WAIT;
                    end
                end
                POLL_WAIT: begin
                    if (gap_expire) begin
                        state <= POLL_RD;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef BUS_INITIATOR_STATS_EN
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            stat_wr <= '0;
            stat_rd <= '0;
            stat_to <= '0;
        end else begin
            if (state == WRITE) begin
                stat_wr <= sat_inc(stat_wr);
            end
            if ((state == READ) || ((state == POLL_RD) && (poll_hit || poll_last))) begin
                stat_rd <= sat_inc(stat_rd);
            end
            if ((state == POLL_RD) && !poll_hit && poll_last) begin
                stat_to <= sat_inc(stat_to);
            end
        end
    end
`endif

endmodule

// File: tb/tb_bus_initiator.sv
// tb/tb_bus_initiator.sv - table-driven bench for bus_initiator
module tb_bus_initiator;

    localparam int P_TIMEOUT = 8;
    localparam int P_GAP     = 4;

    localparam int M_READ  = 0;
    localparam int M_POLL3 = 1;
    localparam int M_ZERO  = 2;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic [31:0] cmd_mask = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_timeout;
    logic        rsp_err;
    logic [31:0] addr_dm;
    logic [31:0] wd_dm;
    logic        we;
    logic [31:0] rd_dm;
`ifdef BUS_INITIATOR_STATS_EN
    logic [15:0] stat_wr;
    logic [15:0] stat_rd;
    logic [15:0] stat_to;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int mode  = M_READ;
    int cyc   = 0;

    int          we_total  = 0;
    int          chg_total = 0;
    logic [31:0] we_addr   = '0;
    logic [31:0] we_data   = '0;
    logic [31:0] prev_addr = '0;

    bus_initiator #(
        .POLL_TIMEOUT (P_TIMEOUT),
        .POLL_GAP     (P_GAP)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .cmd_mask    (cmd_mask),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .rsp_err     (rsp_err),
        .addr_dm     (addr_dm),
        .wd_dm       (wd_dm),
        .we          (we),
`ifdef BUS_INITIATOR_STATS_EN
        .stat_wr     (stat_wr),
        .stat_rd     (stat_rd),
        .stat_to     (stat_to),
`endif
        .rd_dm       (rd_dm)
    );

    always #5 Clk = ~Clk;

    // cyc is 0 in the first cycle after the acceptance edge.
    always @(posedge Clk) begin
        if (cmd_valid && cmd_ready) cyc <= 0;
        else                        cyc <= cyc + 1;
    end

    // Bus target: answers in the same cycle as the address.
    always_comb begin
        rd_dm = 32'hDEAD_BEEF;
        case (mode)
            M_READ:  rd_dm = (addr_dm == 32'h0000_0900) ? 32'h78 : 32'hDEAD_BEEF;
            M_POLL3: rd_dm = (cyc >= 10) ? 32'h1 : 32'h0;
            M_ZERO:  rd_dm = 32'h0;
            default: rd_dm = 32'hDEAD_BEEF;
        endcase
    end

    always @(negedge Clk) begin
        if (we) begin
            we_total <= we_total + 1;
            we_addr  <= addr_dm;
            we_data  <= wd_dm;
        end
        if (addr_dm != prev_addr) chg_total <= chg_total + 1;
        prev_addr <= addr_dm;
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] mask;
        int          mode;
        int          lat;
        logic [31:0] rdata;
        logic        tmo;
        logic        err;
        int          nwe;
    } vec_t;

    vec_t vt[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_cmd(input vec_t v, input int idx);
        int lat;
        int w;
        int we0;
        int chg0;
        @(negedge Clk);
        w = 0;
        while (!cmd_ready && w < 50) begin
            @(negedge Clk);
            w++;
        end
        check($sformatf("v%0d_cmd_ready", idx), {31'b0, cmd_ready}, 32'd1);
        mode      = v.mode;
        cmd_op    = v.op;
        cmd_addr  = v.addr;
        cmd_data  = v.data;
        cmd_mask  = v.mask;
        cmd_valid = 1'b1;
        we0  = we_total;
        chg0 = chg_total;
        @(posedge Clk);
        @(negedge Clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin
            @(negedge Clk);
            lat++;
        end
        check($sformatf("v%0d_latency", idx), lat, v.lat);
        check($sformatf("v%0d_rsp_data", idx), rsp_data, v.rdata);
        check($sformatf("v%0d_rsp_timeout", idx), {31'b0, rsp_timeout}, {31'b0, v.tmo});
        check($sformatf("v%0d_rsp_err", idx), {31'b0, rsp_err}, {31'b0, v.err});
        check($sformatf("v%0d_we_cycles", idx), we_total - we0, v.nwe);
        if (v.nwe > 0) begin
            check($sformatf("v%0d_we_addr", idx), we_addr, v.addr);
            check($sformatf("v%0d_we_data", idx), we_data, v.data);
        end
        if (v.op == 2'b11) begin
            check($sformatf("v%0d_addr_changes", idx), chg_total - chg0, 0);
        end
        rsp_ready = 1'b1;
        @(negedge Clk);
        rsp_ready = 1'b0;
        check($sformatf("v%0d_rsp_valid_drop", idx), {31'b0, rsp_valid}, 32'd0);
    endtask

    initial begin
        vt[0] = '{2'b00, 32'h0000_0804, 32'h5,    32'h0,  M_READ,  2,  32'h0,         1'b0, 1'b0, 1};
        vt[1] = '{2'b01, 32'h0000_0900, 32'h0,    32'h0,  M_READ,  2,  32'h78,        1'b0, 1'b0, 0};
        vt[2] = '{2'b10, 32'h0000_0808, 32'h1,    32'h1,  M_POLL3, 12, 32'h1,         1'b0, 1'b0, 0};
        vt[3] = '{2'b10, 32'h0000_0808, 32'h1,    32'h1,  M_ZERO,  37, 32'h0,         1'b1, 1'b0, 0};
        vt[4] = '{2'b11, 32'h0000_0C00, 32'h7,    32'h7,  M_ZERO,  1,  32'h0,         1'b0, 1'b1, 0};
        vt[5] = '{2'b10, 32'h0000_0900, 32'hFFFF, 32'h0,  M_READ,  2,  32'h78,        1'b0, 1'b0, 0};
        vt[6] = '{2'b01, 32'h0000_0A00, 32'h0,    32'h0,  M_READ,  2,  32'hDEAD_BEEF, 1'b0, 1'b0, 0};
        vt[7] = '{2'b10, 32'h0000_0900, 32'h70,   32'hF0, M_READ,  2,  32'h78,        1'b0, 1'b0, 0};

        // Reset state
        @(negedge Clk);
        check("reset_cmd_ready", {31'b0, cmd_ready}, 32'd0);
        check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset_we", {31'b0, we}, 32'd0);
        check("reset_addr_dm", addr_dm, 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);
        Rst = 1'b0;
        @(negedge Clk);
        check("post_reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            run_cmd(vt[i], i);
        end

        // Backpressure: response held for 5 cycles with rsp_ready low
        begin
            int w;
            @(negedge Clk);
            mode = M_READ; cmd_op = 2'b01; cmd_addr = 32'h0000_0900; cmd_valid = 1'b1;
            @(posedge Clk);
            @(negedge Clk);
            cmd_valid = 1'b0;
            w = 0;
            while (!rsp_valid && w < 50) begin
                @(negedge Clk);
                w++;
            end
            for (int c = 0; c < 5; c++) begin
                check($sformatf("bp%0d_rsp_valid", c), {31'b0, rsp_valid}, 32'd1);
                check($sformatf("bp%0d_rsp_data", c), rsp_data, 32'h78);
                check($sformatf("bp%0d_cmd_ready", c), {31'b0, cmd_ready}, 32'd0);
                @(negedge Clk);
            end
            rsp_ready = 1'b1;
            @(negedge Clk);
            rsp_ready = 1'b0;
            check("bp_released", {31'b0, rsp_valid}, 32'd0);
        end

        // Write leaves a nonzero wd_dm, then reset during POLL_WAIT
        run_cmd(vt[0], 8);
        begin
            int seen;
            @(negedge Clk);
            mode = M_ZERO; cmd_op = 2'b10; cmd_addr = 32'h0000_0808;
            cmd_data = 32'h1; cmd_mask = 32'h1; cmd_valid = 1'b1;
            @(posedge Clk);
            @(negedge Clk);
            cmd_valid = 1'b0;
            @(negedge Clk);
            @(negedge Clk);
            Rst = 1'b1;
            #1;
            check("rst_we", {31'b0, we}, 32'd0);
            check("rst_addr_dm", addr_dm, 32'd0);
            check("rst_wd_dm", wd_dm, 32'd0);
            check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
            check("rst_rsp_data", rsp_data, 32'd0);
            check("rst_rsp_timeout", {31'b0, rsp_timeout}, 32'd0);
            check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
            check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
            @(negedge Clk);
            @(negedge Clk);
            Rst = 1'b0;
            @(negedge Clk);
            check("rst_release_cmd_ready", {31'b0, cmd_ready}, 32'd1);
            seen = 0;
            for (int c = 0; c < 45; c++) begin
                if (rsp_valid) seen++;
                @(negedge Clk);
            end
            check("rst_no_response", seen, 0);
        end

        run_cmd(vt[1], 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_initiator.md
BUS_INITIATOR -- requirements
Module: bus_initiator

Interface
REQ-001 Parameter POLL_TIMEOUT, default 1024, is the maximum number of poll reads before a poll command gives up.
REQ-002 Parameter POLL_GAP, default 4, is the number of idle bus cycles between consecutive poll reads (legal values 1 or more).
REQ-003 Clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Rst  input  1  reset, asynchronous and active-high.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  block accepts a command; the command transfers when cmd_valid and cmd_ready are both high at a rising edge.
REQ-007 cmd_op  input  2  operation: 00 write, 01 read, 10 poll, 11 reserved.
REQ-008 cmd_addr  input  32  byte address of the bus target.
REQ-009 cmd_data  input  32  write data for a write; expected value for a poll.
REQ-010 cmd_mask  input  32  compare mask for a poll; ignored by other operations.
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  consumer accepts the response.
REQ-013 rsp_data  output  32  read data, or the last polled value.
REQ-014 rsp_timeout  output  1  the poll ended without a match.
REQ-015 rsp_err  output  1  the command used the reserved opcode.
REQ-016 addr_dm  output  32  bus address.
REQ-017 wd_dm  output  32  bus write data.
REQ-018 we  output  1  bus write enable.
REQ-019 rd_dm  input  32  bus read data; it is valid in the same cycle that addr_dm is driven.

Function
REQ-020 The controller SHALL be a state machine with states IDLE, WRITE, READ, POLL_RD, POLL_WAIT and RESP.
REQ-021 cmd_ready SHALL be high only in IDLE.
REQ-022 On acceptance, the block SHALL register op, addr, data and mask, then move to WRITE (op 00), READ (op 01), POLL_RD (op 10) or RESP with rsp_err=1 (op 11).
REQ-023 WRITE SHALL drive we=1, addr_dm and wd_dm from the registered values for exactly one cycle, then go to RESP; we SHALL be 0 in every other state.
REQ-024 READ SHALL drive addr_dm for one cycle, capture rd_dm into rsp_data at the end of that cycle, then go to RESP.
REQ-025 POLL_RD SHALL capture rd_dm and increment the poll counter.
REQ-026 From POLL_RD, if (rd_dm & mask) equals (data & mask), the block SHALL go to RESP with rsp_timeout=0.
REQ-027 From POLL_RD, if there is no match and the counter equals POLL_TIMEOUT, the block SHALL go to RESP with rsp_timeout=1.
REQ-028 From POLL_RD, in all other cases the block SHALL go to POLL_WAIT.
REQ-029 POLL_WAIT SHALL last exactly POLL_GAP cycles, then return to POLL_RD.
REQ-030 A mask of 0 SHALL match on the first read.
REQ-031 RESP SHALL hold rsp_valid=1 and stable response fields until rsp_ready=1, then return to IDLE.
REQ-032 rsp_valid SHALL never rise in the cycle in which a command is accepted.
REQ-033 addr_dm and wd_dm SHALL hold their last driven values outside bus cycles.
REQ-034 Latency from acceptance to rsp_valid SHALL be 2 cycles for a write or a read, 1 cycle for a reserved opcode, and 2+(k-1)*(POLL_GAP+1) cycles for a poll that ends on its k-th read.
REQ-035 The poll counter SHALL be 16 bits, cleared on acceptance, and saturating.

Reset
REQ-036 Asserting Rst SHALL immediately force IDLE, including mid-poll or mid-response, with any in-flight command discarded.
REQ-037 During reset, the following outputs SHALL be 0: we, addr_dm, wd_dm, rsp_valid, rsp_data, rsp_timeout and rsp_err.
REQ-038 cmd_ready SHALL be 1 from the first edge after Rst deasserts.

Configuration
REQ-039 With BUS_INITIATOR_STATS_EN defined, the block SHALL add outputs stat_wr, stat_rd and stat_to (each 16 bits, saturating, cleared by reset) that count completed writes, completed reads/polls and poll timeouts.
REQ-040 Without BUS_INITIATOR_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-041 The opcode encodings and the state enumeration SHALL live in the shared package bus_initiator_pkg.
REQ-042 The poll counter and the gap counter SHALL be a single sub-module, poll_timer, with load, tick, expire and count outputs.

Verification
REQ-043 Write: op 00, addr 0x0000_0804, data 0x5 -> exactly one cycle with we=1, addr_dm=0x804 and wd_dm=0x5; rsp_valid two cycles after acceptance.
REQ-044 Read: op 01, addr 0x0000_0900, target returns 0x78 -> rsp_data=0x78, rsp_timeout=0, rsp_err=0.
REQ-045 Poll match: addr 0x808, mask 0x1, data 0x1, target returns 0,0,1 -> three reads spaced POLL_GAP+1 cycles apart; rsp_data=0x1.
REQ-046 Poll timeout: POLL_TIMEOUT=8, target always returns 0 -> exactly 8 reads, then rsp_timeout=1.
REQ-047 Backpressure: rsp_ready held low for 5 cycles -> response fields stable and cmd_ready=0 throughout.
REQ-048 Reset and reserved opcode: Rst asserted during POLL_WAIT -> IDLE with all outputs 0 and no response issued; op 11 -> rsp_err=1 one cycle after acceptance, with no bus activity.
